// File: rtl/obi_sram_responder.sv
// rtl/obi_sram_responder.sv - OBI responder driving a 1-cycle-latency single-port SRAM bank.
// Optional: define OBI_SRAM_RESPONDER_RANDOM_STALL_EN for LFSR-driven random grant stalls.
package obi_sram_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_sram_responder
  import obi_sram_pkg::*;
#(
  parameter int unsigned NUM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  localparam int unsigned ADDR_W     = $clog2(NUM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  obi_req_t          obi_req_i,
  output obi_resp_t         obi_resp_o,
  output logic              sram_req_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt;
  logic       stall;
  logic       rvalid_q;
  logic       resp_we_q;

`ifdef OBI_SRAM_RESPONDER_RANDOM_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (obi_req_i.req) begin
          if (WAIT_CYCLES == 0) begin
            gnt = !stall;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      WAIT: begin
        // A master dropping req before gnt abandons the transfer entirely.
        if (!obi_req_i.req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WAIT_N) begin
          if (!stall) begin
            gnt     = 1'b1;
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (rst_i) begin
      gnt = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rvalid_q  <= 1'b0;
      resp_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt;
      if (gnt) begin
        resp_we_q <= obi_req_i.we;
      end
    end
  end

  assign sram_req_o   = gnt;
  assign sram_we_o    = obi_req_i.we;
  assign sram_be_o    = obi_req_i.be;
  assign sram_addr_o  = obi_req_i.addr[ADDR_W+1:2];
  assign sram_wdata_o = obi_req_i.wdata;

  // Writes answer with zero; read data comes straight from the SRAM output port.
  assign obi_resp_o.gnt    = gnt;
  assign obi_resp_o.rvalid = rvalid_q;
  assign obi_resp_o.rdata  = (rvalid_q && !resp_we_q) ? sram_rdata_i : 32'h0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{obi_req_i.addr[31:ADDR_W+2], obi_req_i.addr[1:0]};

endmodule

// File: tb/tb_obi_sram_responder.sv
// tb/tb_obi_sram_responder.sv - directed self-checking bench, zero-wait and three-wait instances.
module tb_obi_sram_responder;
  import obi_sram_pkg::*;

  localparam int unsigned NW = 1024;
  localparam int unsigned AW = $clog2(NW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obi_req_t  req0, req3;
  obi_resp_t resp0, resp3;
  logic          s0_req, s0_we, s3_req, s3_we;
  logic [3:0]    s0_be, s3_be;
  logic [AW-1:0] s0_addr, s3_addr;
  logic [31:0]   s0_wdata, s3_wdata, s0_rdata, s3_rdata;

  int n_cmp = 0;
  int n_err = 0;

  obi_sram_responder #(.NUM_WORDS(NW), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req0), .obi_resp_o(resp0),
    .sram_req_o(s0_req), .sram_we_o(s0_we), .sram_be_o(s0_be),
    .sram_addr_o(s0_addr), .sram_wdata_o(s0_wdata), .sram_rdata_i(s0_rdata)
  );

  obi_sram_responder #(.NUM_WORDS(NW), .WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .obi_req_i(req3), .obi_resp_o(resp3),
    .sram_req_o(s3_req), .sram_we_o(s3_we), .sram_be_o(s3_be),
    .sram_addr_o(s3_addr), .sram_wdata_o(s3_wdata), .sram_rdata_i(s3_rdata)
  );

  // Behavioural 1-cycle-latency SRAM banks.
  logic [31:0] mem0 [NW];
  logic [31:0] mem3 [NW];

  always @(posedge clk) begin
    if (s0_req) begin
      if (s0_we) begin
        for (int b = 0; b < 4; b++) if (s0_be[b]) mem0[s0_addr][8*b +: 8] <= s0_wdata[8*b +: 8];
      end else begin
        s0_rdata <= mem0[s0_addr];
      end
    end
  end

  always @(posedge clk) begin
    if (s3_req) begin
      if (s3_we) begin
        for (int b = 0; b < 4; b++) if (s3_be[b]) mem3[s3_addr][8*b +: 8] <= s3_wdata[8*b +: 8];
      end else begin
        s3_rdata <= mem3[s3_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request at the falling edge, then settle before checking.
  task automatic drive(input int sel, input logic r, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    if (sel == 0) req0 = '{req: r, we: we, be: be, addr: addr, wdata: wdata};
    else          req3 = '{req: r, we: we, be: be, addr: addr, wdata: wdata};
    #1;
  endtask

  logic [3:0] exp_gnt3 [4];

  initial begin
    req0 = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'h10, wdata: 32'hDEADBEEF};
    req3 = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h10, wdata: 32'h0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", resp0.gnt, 0);
    check("rst_sreq0", s0_req, 0);
    check("rst_rvalid0", resp0.rvalid, 0);
    check("rst_rdata0", resp0.rdata, 0);
    check("rst_gnt3", resp3.gnt, 0);
    check("rst_rvalid3", resp3.rvalid, 0);
    req3.req = 1'b0;

    // Release reset together with a write: grant must be immediate.
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("wr_gnt", resp0.gnt, 1);
    check("wr_sreq", s0_req, 1);
    check("wr_saddr", 32'(s0_addr), 4);
    check("wr_swe", s0_we, 1);
    check("wr_swdata", s0_wdata, 32'hDEADBEEF);
    drive(0, 1, 0, 4'hF, 32'h10, 0);
    check("rd_gnt", resp0.gnt, 1);
    check("rd_swe", s0_we, 0);
    check("wr_rvalid", resp0.rvalid, 1);
    check("wr_rdata", resp0.rdata, 0);
    drive(0, 0, 0, 4'hF, 0, 0);
    check("idle_gnt", resp0.gnt, 0);
    check("idle_sreq", s0_req, 0);
    check("rd_rvalid", resp0.rvalid, 1);
    check("rd_rdata", resp0.rdata, 32'hDEADBEEF);
    drive(0, 0, 0, 4'hF, 0, 0);
    check("idle_rvalid", resp0.rvalid, 0);
    check("idle_rdata", resp0.rdata, 0);

    // Four writes then four reads, each back to back.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 4'hF, 32'h40 + 4 * k, 32'hA0A00000 + k);
      check("b2b_wr_gnt", resp0.gnt, 1);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 0, 4'hF, 32'h40 + 4 * k, 0);
      check("b2b_rd_gnt", resp0.gnt, 1);
      check("b2b_saddr", 32'(s0_addr), 16 + k);
      check("b2b_rvalid", resp0.rvalid, 1);
      check("b2b_rdata", resp0.rdata, (k == 0) ? 32'h0 : 32'hA0A00000 + (k - 1));
    end
    drive(0, 0, 0, 4'hF, 0, 0);
    check("b2b_last_rvalid", resp0.rvalid, 1);
    check("b2b_last_rdata", resp0.rdata, 32'hA0A00003);

    // Partial write then readback through an aliased address.
    drive(0, 1, 1, 4'hF, 32'h20, 32'h11223344);
    drive(0, 1, 1, 4'b0100, 32'h20, 32'h00AB0000);
    check("pw_sbe", 32'(s0_be), 32'h4);
    check("pw_saddr", 32'(s0_addr), 8);
    drive(0, 1, 0, 4'hF, 32'h20 + 4 * NW, 0);
    check("alias_saddr", 32'(s0_addr), 8);
    check("alias_gnt", resp0.gnt, 1);
    drive(0, 0, 0, 4'hF, 0, 0);
    check("pw_rdata", resp0.rdata, 32'h11AB3344);

    // Reset in the grant cycle discards the pending response.
    drive(0, 1, 0, 4'hF, 32'h40, 0);
    check("rg_gnt", resp0.gnt, 1);
    rst = 1'b1;
    #1;
    check("rg_gnt_forced", resp0.gnt, 0);
    check("rg_sreq_forced", s0_req, 0);
    @(negedge clk);
    rst = 1'b0;
    req0.req = 1'b0;
    #1;
    check("rg_rvalid", resp0.rvalid, 0);
    check("rg_rdata", resp0.rdata, 0);
    drive(0, 1, 0, 4'hF, 32'h44, 0);
    check("rg_new_gnt", resp0.gnt, 1);
    drive(0, 0, 0, 4'hF, 0, 0);
    check("rg_new_rvalid", resp0.rvalid, 1);
    check("rg_new_rdata", resp0.rdata, 32'hA0A00001);

    // Three wait states: grant on the 4th cycle of req.
    exp_gnt3[0] = 0; exp_gnt3[1] = 0; exp_gnt3[2] = 0; exp_gnt3[3] = 1;
    for (int c = 0; c < 4; c++) begin
      drive(3, 1, 1, 4'hF, 32'h10, 32'hCAFEF00D);
      check("w3_wr_gnt", resp3.gnt, 32'(exp_gnt3[c]));
      check("w3_wr_sreq", s3_req, 32'(exp_gnt3[c]));
    end
    for (int c = 0; c < 4; c++) begin
      drive(3, 1, 0, 4'hF, 32'h10, 0);
      check("w3_rd_gnt", resp3.gnt, 32'(exp_gnt3[c]));
      check("w3_rvalid", resp3.rvalid, (c == 0) ? 32'h1 : 32'h0);
      if (c == 0) check("w3_wr_rdata", resp3.rdata, 0);
    end
    drive(3, 0, 0, 4'hF, 0, 0);
    check("w3_rd_rvalid", resp3.rvalid, 1);
    check("w3_rd_rdata", resp3.rdata, 32'hCAFEF00D);

    // Abandoned request restarts the wait count from scratch.
    drive(3, 1, 0, 4'hF, 32'h10, 0);
    check("ab_gnt_a", resp3.gnt, 0);
    drive(3, 1, 0, 4'hF, 32'h10, 0);
    check("ab_gnt_b", resp3.gnt, 0);
    drive(3, 0, 0, 4'hF, 0, 0);
    check("ab_drop_gnt", resp3.gnt, 0);
    check("ab_drop_rvalid", resp3.rvalid, 0);
    for (int c = 0; c < 4; c++) begin
      drive(3, 1, 0, 4'hF, 32'h10, 0);
      check("ab_regnt", resp3.gnt, 32'(exp_gnt3[c]));
    end
    drive(3, 0, 0, 4'hF, 0, 0);
    check("ab_rvalid", resp3.rvalid, 1);
    check("ab_rdata", resp3.rdata, 32'hCAFEF00D);
    drive(3, 0, 0, 4'hF, 0, 0);
    check("ab_rvalid_end", resp3.rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
